// File: rtl/alu_muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the MIPS datapath: one bit per clock,
// results land in Hi/Lo with a one-cycle Done pulse.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             DivByZero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int ACC_W = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic               busy_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               is_div_r;
  logic               neg_q_r;
  logic               neg_rem_r;
  logic               b_zero_r;
  logic [WIDTH-1:0]   a_raw_r;
  logic [WIDTH:0]     opnd_r;
  logic [ACC_W-1:0]   acc_r;

  logic               sa_s;
  logic               sb_s;
  logic [WIDTH:0]     mag_a_s;
  logic [WIDTH:0]     mag_b_s;
  logic [WIDTH:0]     hi_sum_s;
  logic [ACC_W-1:0]   mul_next_s;
  logic [WIDTH:0]     trial_s;
  logic [WIDTH:0]     diff_s;
  logic [ACC_W-1:0]   div_next_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   hi_s;
  logic [WIDTH-1:0]   lo_s;
  logic               dbz_s;

  // Magnitude in W+1 bits so that the most negative operand stays exact.
  function automatic logic [WIDTH:0] abs_ext(input logic [WIDTH-1:0] v, input logic neg);
    logic [WIDTH:0] ext;
    ext = {v[WIDTH-1] & neg, v};
    return neg ? (~ext + {{WIDTH{1'b0}}, 1'b1}) : ext;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign sa_s    = Op[0] & A[WIDTH-1];
  assign sb_s    = Op[0] & B[WIDTH-1];
  assign mag_a_s = abs_ext(A, sa_s);
  assign mag_b_s = abs_ext(B, sb_s);
  assign Busy    = busy_r;

  // One iteration step for both algorithms; acc_r holds {high part, low word}.
  always_comb begin
    hi_sum_s   = {(WIDTH+1){1'b0}};
    mul_next_s = {ACC_W{1'b0}};
    trial_s    = {(WIDTH+1){1'b0}};
    diff_s     = {(WIDTH+1){1'b0}};
    div_next_s = {ACC_W{1'b0}};
    if (acc_r[0]) begin
      hi_sum_s = acc_r[ACC_W-1:WIDTH] + opnd_r;
    end else begin
      hi_sum_s = acc_r[ACC_W-1:WIDTH];
    end
    mul_next_s = {1'b0, hi_sum_s, acc_r[WIDTH-1:1]};
    trial_s    = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    diff_s     = trial_s - opnd_r;
    if (trial_s >= opnd_r) begin
      div_next_s = {diff_s, acc_r[WIDTH-2:0], 1'b1};
    end else begin
      div_next_s = {trial_s, acc_r[WIDTH-2:0], 1'b0};
    end
  end

  // Sign fix-up and divide-by-zero override applied in the FIX cycle.
  always_comb begin
    prod_s = acc_r[2*WIDTH-1:0];
    quo_s  = acc_r[WIDTH-1:0];
    rem_s  = acc_r[2*WIDTH-1:WIDTH];
    hi_s   = {WIDTH{1'b0}};
    lo_s   = {WIDTH{1'b0}};
    dbz_s  = 1'b0;
    if (!is_div_r) begin
      if (neg_q_r) begin
        prod_s = neg_2w(acc_r[2*WIDTH-1:0]);
      end else begin
        prod_s = acc_r[2*WIDTH-1:0];
      end
      hi_s = prod_s[2*WIDTH-1:WIDTH];
      lo_s = prod_s[WIDTH-1:0];
    end else if (b_zero_r) begin
      hi_s  = a_raw_r;
      lo_s  = {WIDTH{1'b1}};
      dbz_s = 1'b1;
    end else begin
      hi_s = neg_rem_r ? neg_w(rem_s) : rem_s;
      lo_s = neg_q_r ? neg_w(quo_s) : quo_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (Start) begin
          state_s = CALC;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == CNT_W'(1)) begin
          state_s = FIX;
        end else begin
          state_s = CALC;
        end
      end
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register and the registered Busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
    end
  end

  // Operand latch, iteration datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= {CNT_W{1'b0}};
      is_div_r  <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
      b_zero_r  <= 1'b0;
      a_raw_r   <= {WIDTH{1'b0}};
      opnd_r    <= {(WIDTH+1){1'b0}};
      acc_r     <= {ACC_W{1'b0}};
      Hi        <= {WIDTH{1'b0}};
      Lo        <= {WIDTH{1'b0}};
      DivByZero <= 1'b0;
      Done      <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (Start) begin
            is_div_r  <= Op[1];
            neg_q_r   <= sa_s ^ sb_s;
            neg_rem_r <= sa_s;
            b_zero_r  <= Op[1] & (B == {WIDTH{1'b0}});
            a_raw_r   <= A;
            cnt_r     <= CNT_W'(WIDTH);
            // MUL keeps |A| as the addend; DIV keeps |B| as the divisor.
            opnd_r    <= Op[1] ? mag_b_s : mag_a_s;
            acc_r     <= {{(WIDTH+1){1'b0}}, (Op[1] ? mag_a_s[WIDTH-1:0] : mag_b_s[WIDTH-1:0])};
          end
        end
        CALC: begin
          acc_r <= is_div_r ? div_next_s : mul_next_s;
          cnt_r <= cnt_r - CNT_W'(1);
        end
        FIX: begin
          Hi        <= hi_s;
          Lo        <= lo_s;
          DivByZero <= dbz_s;
          Done      <= 1'b1;
        end
        default: begin
          Done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq at WIDTH=32 and WIDTH=8.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start8;
  logic [1:0]  op, op8;
  logic [31:0] a, b;
  logic [7:0]  a8, b8;
  logic        busy, done, dbz;
  logic        busy8, done8, dbz8;
  logic [31:0] hi, lo;
  logic [7:0]  hi8, lo8;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t sb32[$];
  exp_t sb8[$];
  exp_t e32, e8;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .Start(start), .Op(op), .A(a), .B(b),
    .Busy(busy), .Done(done), .Hi(hi), .Lo(lo), .DivByZero(dbz)
  );

  alu_muldiv_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .Start(start8), .Op(op8), .A(a8), .B(b8),
    .Busy(busy8), .Done(done8), .Hi(hi8), .Lo(lo8), .DivByZero(dbz8)
  );

  function automatic exp_t mk(input logic [31:0] h, input logic [31:0] l, input logic z);
    exp_t e;
    e.hi = h; e.lo = l; e.dbz = z;
    return e;
  endfunction

  // Reference arithmetic on 64-bit integers, truncated to w bits.
  function automatic exp_t model(input int w, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] mask, p;
    longint      xs, ys, q, r;
    exp_t        e;
    mask = (64'd1 << w) - 64'd1;
    xs = longint'({32'd0, x} & mask);
    ys = longint'({32'd0, y} & mask);
    if (o[0] && ((xs >> (w - 1)) & 64'sd1) != 64'sd0) xs = xs - (64'sd1 << w);
    if (o[0] && ((ys >> (w - 1)) & 64'sd1) != 64'sd0) ys = ys - (64'sd1 << w);
    if (!o[1]) begin
      p = xs * ys;
      e = mk(32'((p >> w) & mask), 32'(p & mask), 1'b0);
    end else if (ys == 64'sd0) begin
      e = mk(x & mask[31:0], mask[31:0], 1'b1);
    end else begin
      q = xs / ys;
      r = xs % ys;
      e = mk(32'(r) & mask[31:0], 32'(q) & mask[31:0], 1'b0);
    end
    return e;
  endfunction

  // Scoreboard for the 32-bit unit: pop one expectation per Done.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_vec++;
      if (sb32.size() == 0) begin
        n_err++;
        $display("FAIL done32_unexpected: got Done=1 with nothing pending, required Done=0");
      end else begin
        e32 = sb32.pop_front();
        n_vec += 3;
        if (hi !== e32.hi) begin n_err++; $display("FAIL hi32: got %h required %h", hi, e32.hi); end
        if (lo !== e32.lo) begin n_err++; $display("FAIL lo32: got %h required %h", lo, e32.lo); end
        if (dbz !== e32.dbz) begin n_err++; $display("FAIL dbz32: got %b required %b", dbz, e32.dbz); end
      end
      if (busy !== 1'b0) begin n_err++; $display("FAIL busy_in_done32: got %b required 0", busy); end
    end
  end

  // Scoreboard for the 8-bit unit.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      n_vec++;
      if (sb8.size() == 0) begin
        n_err++;
        $display("FAIL done8_unexpected: got Done=1 with nothing pending, required Done=0");
      end else begin
        e8 = sb8.pop_front();
        n_vec += 2;
        if (hi8 !== e8.hi[7:0]) begin n_err++; $display("FAIL hi8: got %h required %h", hi8, e8.hi[7:0]); end
        if (lo8 !== e8.lo[7:0]) begin n_err++; $display("FAIL lo8: got %h required %h", lo8, e8.lo[7:0]); end
      end
    end
  end

  // Start is held for exactly one edge; operands then scrambled to prove they were latched.
  task automatic drive32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input exp_t e, input bit do_push);
    if (do_push) sb32.push_back(e);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic drive8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y, input exp_t e);
    sb8.push_back(e);
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(negedge clk);
    start8 = 1'b0; op8 = 2'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  // Waits (bounded) for Done; lat counts clocks after the Start edge.
  task automatic wait32(output int lat, output int busy_n);
    lat = 0; busy_n = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait8(output int lat, output int busy_n);
    lat = 0; busy_n = 0;
    while (done8 !== 1'b1 && lat < 200) begin
      if (busy8 === 1'b1) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    start8 = 1'b0; op8 = 2'b00; a8 = 8'd0; b8 = 8'd0;
    #2 rst_n = 1'b0;
    #1;
    n_vec += 5;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
    if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b required 0", done); end
    if (hi !== 32'd0) begin n_err++; $display("FAIL reset_hi: got %h required 0", hi); end
    if (lo !== 32'd0) begin n_err++; $display("FAIL reset_lo: got %h required 0", lo); end
    if (dbz !== 1'b0) begin n_err++; $display("FAIL reset_dbz: got %b required 0", dbz); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_multu;
    int lat, bn;
    @(negedge clk);
    drive32(2'b00, 32'hFFFFFFFE, 32'hFFFFFFFF, mk(32'hFFFFFFFD, 32'h00000002, 1'b0), 1'b1);
    wait32(lat, bn);
    n_vec += 2;
    if (lat != 33) begin n_err++; $display("FAIL multu_latency: got %0d required 33", lat); end
    if (bn != 33) begin n_err++; $display("FAIL multu_busy_cycles: got %0d required 33", bn); end
  endtask

  task automatic test_mult_signed;
    int lat, bn;
    @(negedge clk);
    drive32(2'b01, 32'hFFFFFFFE, 32'hFFFFFFFF, mk(32'h00000000, 32'h00000002, 1'b0), 1'b1);
    wait32(lat, bn);
    @(negedge clk);
    drive32(2'b01, 32'h80000000, 32'h80000000, mk(32'h40000000, 32'h00000000, 1'b0), 1'b1);
    wait32(lat, bn);
    n_vec++;
    if (lat != 33) begin n_err++; $display("FAIL mult_latency: got %0d required 33", lat); end
  endtask

  task automatic test_div;
    int lat, bn;
    @(negedge clk);
    drive32(2'b10, 32'h000000F6, 32'h0000000A, mk(32'h00000006, 32'h00000018, 1'b0), 1'b1);
    wait32(lat, bn);
    @(negedge clk);
    drive32(2'b11, 32'hFFFFFFF9, 32'h00000002, mk(32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0), 1'b1);
    wait32(lat, bn);
    n_vec++;
    if (lat != 33) begin n_err++; $display("FAIL div_latency: got %0d required 33", lat); end
  endtask

  task automatic test_div_by_zero;
    int lat, bn;
    @(negedge clk);
    drive32(2'b10, 32'h00001234, 32'h0, mk(32'h00001234, 32'hFFFFFFFF, 1'b1), 1'b1);
    wait32(lat, bn);
    n_vec++;
    if (lat != 33) begin n_err++; $display("FAIL divz_latency: got %0d required 33", lat); end
    @(negedge clk);
    drive32(2'b00, 32'd3, 32'd5, mk(32'h0, 32'h0000000F, 1'b0), 1'b1);
    wait32(lat, bn);
    @(negedge clk);
    drive32(2'b11, 32'hFFFFFFFB, 32'h0, mk(32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1), 1'b1);
    wait32(lat, bn);
  endtask

  task automatic test_div_overflow;
    int lat, bn;
    @(negedge clk);
    drive32(2'b11, 32'h80000000, 32'hFFFFFFFF, mk(32'h00000000, 32'h80000000, 1'b0), 1'b1);
    wait32(lat, bn);
  endtask

  task automatic test_sweep;
    logic [31:0] edges [5];
    logic [31:0] x, y;
    int lat, bn;
    edges[0] = 32'h0; edges[1] = 32'h1; edges[2] = 32'hFFFFFFFF;
    edges[3] = 32'h80000000; edges[4] = 32'h7FFFFFFF;
    for (int o = 0; o < 4; o++) begin
      for (int i = 0; i < 7; i++) begin
        if (i < 5) begin
          x = edges[i]; y = edges[(i + 2) % 5];
        end else begin
          x = $urandom; y = $urandom >> (i * 3);
        end
        @(negedge clk);
        drive32(2'(o), x, y, model(32, 2'(o), x, y), 1'b1);
        wait32(lat, bn);
      end
    end
  endtask

  task automatic test_busy_ignore;
    int lat, bn, extra;
    @(negedge clk);
    drive32(2'b00, 32'd7, 32'd9, mk(32'h0, 32'd63, 1'b0), 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'hFFFFFFFF; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    wait32(lat, bn);
    n_vec++;
    if (done !== 1'b1) begin n_err++; $display("FAIL busy_ignore_done: got %b required 1", done); end
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    n_vec++;
    if (extra != 0) begin n_err++; $display("FAIL busy_ignore_extra_done: got %0d required 0", extra); end
  endtask

  task automatic test_back_to_back;
    int lat, bn;
    @(negedge clk);
    drive32(2'b01, 32'hFFFFFFF0, 32'd3, mk(32'hFFFFFFFF, 32'hFFFFFFD0, 1'b0), 1'b1);
    wait32(lat, bn);
    drive32(2'b10, 32'd1000, 32'd7, mk(32'd6, 32'd142, 1'b0), 1'b1);
    wait32(lat, bn);
    n_vec++;
    if (lat != 33) begin n_err++; $display("FAIL back_to_back_latency: got %0d required 33", lat); end
  endtask

  task automatic test_reset_mid_op;
    int seen;
    @(negedge clk);
    drive32(2'b10, 32'h0000FFFF, 32'd3, mk(32'h0, 32'h0, 1'b0), 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec += 4;
    if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b required 0", busy); end
    if (hi !== 32'd0) begin n_err++; $display("FAIL midreset_hi: got %h required 0", hi); end
    if (lo !== 32'd0) begin n_err++; $display("FAIL midreset_lo: got %h required 0", lo); end
    if (done !== 1'b0) begin n_err++; $display("FAIL midreset_done: got %b required 0", done); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (45) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    n_vec++;
    if (seen != 0) begin n_err++; $display("FAIL midreset_no_done: got %0d Done pulses required 0", seen); end
  endtask

  task automatic test_width8;
    int lat, bn;
    @(negedge clk);
    drive8(2'b00, 8'hFE, 8'hFF, mk(32'hFD, 32'h02, 1'b0));
    wait8(lat, bn);
    n_vec += 2;
    if (lat != 9) begin n_err++; $display("FAIL w8_mul_latency: got %0d required 9", lat); end
    if (bn != 9) begin n_err++; $display("FAIL w8_busy_cycles: got %0d required 9", bn); end
    @(negedge clk);
    drive8(2'b10, 8'hF6, 8'h0A, mk(32'h06, 32'h18, 1'b0));
    wait8(lat, bn);
    n_vec++;
    if (lat != 9) begin n_err++; $display("FAIL w8_div_latency: got %0d required 9", lat); end
    @(negedge clk);
    drive8(2'b11, 8'h80, 8'hFF, model(8, 2'b11, 32'h80, 32'hFF));
    wait8(lat, bn);
    @(negedge clk);
    drive8(2'b01, 8'h80, 8'h80, model(8, 2'b01, 32'h80, 32'h80));
    wait8(lat, bn);
    @(negedge clk);
    drive8(2'b11, 8'hE9, 8'h05, model(8, 2'b11, 32'hE9, 32'h05));
    wait8(lat, bn);
  endtask

  initial begin
    test_reset;
    test_multu;
    test_mult_signed;
    test_div;
    test_div_by_zero;
    test_div_overflow;
    test_sweep;
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid_op;
    test_width8;
    repeat (2) @(negedge clk);
    n_vec += 2;
    if (sb32.size() != 0) begin n_err++; $display("FAIL pending32: got %0d outstanding required 0", sb32.size()); end
    if (sb8.size() != 0) begin n_err++; $display("FAIL pending8: got %0d outstanding required 0", sb8.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
